// File: rtl/riscv_defs.sv
// Shared RISC-V definitions: opcodes, ULAOp codes, datapath mux encodings
// and the FSM state type used by the main control unit.
package riscv_defs;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ULAOP_ADD    = 2'b00;
    localparam logic [1:0] ULAOP_BRANCH = 2'b01;
    localparam logic [1:0] ULAOP_RTYPE  = 2'b10;
    localparam logic [1:0] ULAOP_ITYPE  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ULA    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    // Moore control word; PCWrite is assembled from pc_update/branch outside.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ula_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate format selector decoded straight from the opcode; shared with
// the datapath so both sides agree on the immediate layout.
import riscv_defs::*;

module imm_src_dec (
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback
// sequencing for lw, sw, R-type, addi and beq.
import riscv_defs::*;

module unidade_controle #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ULAOp,
    output logic [1:0] ImmSrc,
    output logic       instr_invalida
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // Every write strobe comes from state alone, so an async reset can never
    // leave a half-finished store or writeback behind.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.pc_update  = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.ula_op     = ULAOP_ADD;
                w_ctrl.result_src = RES_ULA;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ula_op    = ULAOP_ADD;
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ula_op    = ULAOP_ADD;
            end
            S_MEMREAD: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.ula_op    = ULAOP_RTYPE;
            end
            S_EXECI: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ula_op    = ULAOP_ITYPE;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.ula_op     = ULAOP_BRANCH;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.branch     = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign PCWrite        = w_ctrl.pc_update | (w_ctrl.branch & zero);
    assign AdrSrc         = w_ctrl.adr_src;
    assign MemWrite       = w_ctrl.mem_write;
    assign IRWrite        = w_ctrl.ir_write;
    assign RegWrite       = w_ctrl.reg_write;
    assign ResultSrc      = w_ctrl.result_src;
    assign ALUSrcA        = w_ctrl.alu_src_a;
    assign ALUSrcB        = w_ctrl.alu_src_b;
    assign ULAOp          = w_ctrl.ula_op;
    assign instr_invalida = (r_state == S_DECODE) && !op_supported(op);

    imm_src_dec u_imm_src_dec (
        .op     (op),
        .ImmSrc (ImmSrc)
    );

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized instruction streams against a per-instruction-class step table,
// plus hand-computed control words, mid-instruction resets and HALT parking.
module tb_unidade_controle;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111;

    logic       clk = 1'b0, reset = 1'b1, reset_h = 1'b1, zero = 1'b0;
    logic [6:0] op = '0;

    logic       m_pcw, m_adr, m_mw, m_irw, m_rw, m_inv;
    logic [1:0] m_res, m_sa, m_sb, m_ula, m_imm;
    logic       h_pcw, h_adr, h_mw, h_irw, h_rw, h_inv;
    logic [1:0] h_res, h_sa, h_sb, h_ula, h_imm;

    unidade_controle #(.HALT_ON_ILLEGAL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .PCWrite(m_pcw), .AdrSrc(m_adr), .MemWrite(m_mw), .IRWrite(m_irw),
        .RegWrite(m_rw), .ResultSrc(m_res), .ALUSrcA(m_sa), .ALUSrcB(m_sb),
        .ULAOp(m_ula), .ImmSrc(m_imm), .instr_invalida(m_inv)
    );

    unidade_controle #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
        .clk(clk), .reset(reset_h), .op(op), .zero(zero),
        .PCWrite(h_pcw), .AdrSrc(h_adr), .MemWrite(h_mw), .IRWrite(h_irw),
        .RegWrite(h_rw), .ResultSrc(h_res), .ALUSrcA(h_sa), .ALUSrcB(h_sb),
        .ULAOp(h_ula), .ImmSrc(h_imm), .instr_invalida(h_inv)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ULAOp,ImmSrc,instr_invalida}
    wire [15:0] act_m = {m_pcw, m_adr, m_mw, m_irw, m_rw, m_res, m_sa, m_sb, m_ula, m_imm, m_inv};
    wire [15:0] act_h = {h_pcw, h_adr, h_mw, h_irw, h_rw, h_res, h_sa, h_sb, h_ula, h_imm, h_inv};

    int          n_vec = 0, n_bad = 0;
    logic [15:0] exp_m = '0, exp_h = '0, exp_lit = '0;
    bit          chk_m = 1'b0, chk_h = 1'b0, chk_lit = 1'b0, lit_h = 1'b0;
    event        chk_ev;

    always @(negedge clk or chk_ev) begin
        if (chk_m) begin
            n_vec++;
            if (act_m !== exp_m) begin
                n_bad++;
                $display("FAIL ctrl_main t=%0t got %h want %h", $time, act_m, exp_m);
            end
        end
        if (chk_h) begin
            n_vec++;
            if (act_h !== exp_h) begin
                n_bad++;
                $display("FAIL ctrl_halt t=%0t got %h want %h", $time, act_h, exp_h);
            end
        end
        if (chk_lit) begin
            n_vec++;
            if ((lit_h ? act_h : act_m) !== exp_lit) begin
                n_bad++;
                $display("FAIL pinned_word t=%0t got %h want %h", $time,
                         lit_h ? act_h : act_m, exp_lit);
            end
        end
    end

    function automatic int n_steps(input logic [6:0] iop, input bit halt_on);
        case (iop)
            LW:         return 5;
            SW, RT, IT: return 4;
            BQ:         return 3;
            default:    return halt_on ? 14 : 2;
        endcase
    endfunction

    // Expected control word for step s of an instruction whose opcode is iop;
    // cur_op is what is on the op pins this cycle (only ImmSrc follows it).
    function automatic logic [15:0] model(input logic [6:0] iop, input int s,
                                          input logic [6:0] cur_op, input logic z);
        logic pcw, adr, mw, irw, rw, inv;
        logic [1:0] res, sa, sb, ula, imm;
        {pcw, adr, mw, irw, rw, inv} = '0;
        {res, sa, sb, ula} = '0;
        imm = (cur_op == SW) ? 2'b01 : (cur_op == BQ) ? 2'b10 : 2'b00;
        if (s == 0) begin
            pcw = 1; irw = 1; sb = 2'b10; res = 2'b10;
        end else if (s == 1) begin
            sa = 2'b01; sb = 2'b01;
            inv = !(iop inside {LW, SW, RT, IT, BQ});
        end else begin
            case (iop)
                LW: if (s == 2) begin sa = 2'b10; sb = 2'b01; end
                    else if (s == 3) adr = 1;
                    else begin rw = 1; res = 2'b01; end
                SW: if (s == 2) begin sa = 2'b10; sb = 2'b01; end
                    else begin adr = 1; mw = 1; end
                RT: if (s == 2) begin sa = 2'b10; ula = 2'b10; end
                    else rw = 1;
                IT: if (s == 2) begin sa = 2'b10; sb = 2'b01; ula = 2'b11; end
                    else rw = 1;
                BQ: begin sa = 2'b10; ula = 2'b01; pcw = z; end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, res, sa, sb, ula, imm, inv};
    endfunction

    // zmode: 0/1 hold zero, 2 random. rst_step: step at which reset is pulsed
    // (asynchronously, mid-cycle), -1 for none. pin_step/pin_val: literal check.
    task automatic run_instr(input bit h, input logic [6:0] iop, input int zmode,
                             input int rst_step, input int pin_step,
                             input logic [15:0] pin_val);
        logic [15:0] e;
        int len = n_steps(iop, h);
        for (int s = 0; s < len; s++) begin
            op   = (s == 0) ? 7'($urandom) : iop;
            zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            e = model(iop, s, op, zero);
            if (h) exp_h = e; else exp_m = e;
            lit_h   = h;
            exp_lit = pin_val;
            chk_lit = (s == pin_step);
            @(negedge clk);
            if (s == rst_step) begin
                #2;
                if (h) reset_h = 1'b1; else reset = 1'b1;
                #1;
                e = model(iop, 0, op, zero);
                if (h) exp_h = e; else exp_m = e;
                chk_lit = (pin_step >= 0);
                exp_lit = 16'h9440;
                -> chk_ev;
                @(posedge clk); #1;
                if (h) reset_h = 1'b0; else reset = 1'b0;
                chk_lit = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk_lit = 1'b0;
    endtask

    initial begin
        logic [6:0] o;
        int r, rs;
        @(posedge clk); #1;
        exp_m = model(LW, 0, op, zero);
        exp_h = exp_m;
        exp_lit = 16'h9440;
        chk_m = 1; chk_h = 1; chk_lit = 1; lit_h = 0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_h = 0; chk_lit = 0;

        run_instr(0, LW,  2, -1, 4, 16'h0A00);
        run_instr(0, SW,  2, -1, 3, 16'h6002);
        run_instr(0, RT,  2, -1, 2, 16'h0110);
        run_instr(0, IT,  2, -1, 2, 16'h0138);
        run_instr(0, BQ,  1, -1, 2, 16'h810C);
        run_instr(0, BQ,  0, -1, 2, 16'h010C);
        run_instr(0, BAD, 2, -1, 1, 16'h00A1);
        run_instr(0, LW,  2,  3, 3, 16'h4000);

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BQ;
                default: begin
                    o = 7'($urandom);
                    while (o inside {LW, SW, RT, IT, BQ}) o = 7'($urandom);
                end
            endcase
            rs = ($urandom_range(0, 15) == 0) ? $urandom_range(0, n_steps(o, 0) - 1) : -1;
            run_instr(0, o, 2, rs, -1, 16'h0000);
        end

        reset = 1'b1; chk_m = 0;
        reset_h = 1'b0; chk_h = 1;
        run_instr(1, RT,  2, -1, -1, 16'h0000);
        run_instr(1, BAD, 2, 13, 13, 16'h0000);
        run_instr(1, LW,  2, -1, -1, 16'h0000);
        chk_h = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
